// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready operand intake, iterative shift-add multiplier,
// barrel shifts, carry-chained add/sub and a persistent NZCV flag register.
module alu_mc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         set_flags,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         N,
  output logic         Z,
  output logic         C,
  output logic         V
);
  localparam int SHW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_RSB = 4'd2,  OP_BIC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_ORR = 4'd5,  OP_EOR = 4'd6,  OP_XNR = 4'd7;
  localparam logic [3:0] OP_LSL = 4'd8,  OP_LSR = 4'd9,  OP_ASR = 4'd10, OP_ROR = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12, OP_ADC = 4'd13, OP_SBC = 4'd14, OP_MOV = 4'd15;

  state_t         state_q, state_d;
  logic [3:0]     op_q;
  logic [W-1:0]   a_q, b_q, acc_q, result_q;
  logic [SHW-1:0] cnt_q;
  logic           sf_q, cin_q;
  logic           n_q, z_q, c_q, v_q;

  logic           accept, mul_last, wr_res;
  logic [W-1:0]   acc_nxt;

  assign accept   = (state_q == S_IDLE) && in_valid;
  assign mul_last = (state_q == S_MUL) && (cnt_q == SHW'(W - 1));
  assign wr_res   = (state_q == S_EXEC) || mul_last;
  assign acc_nxt  = acc_q + (b_q[cnt_q] ? (a_q << cnt_q) : '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid) state_d = (op == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: state_d = S_DONE;
      S_MUL:  if (mul_last) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Adder operand steering: subtracts fold into x + ~y + cin.
  logic [W-1:0] ax, ay;
  logic         acin;
  logic [W:0]   sum;
  always_comb begin
    ax   = a_q;
    ay   = b_q;
    acin = 1'b0;
    case (op_q)
      OP_SUB: begin ay = ~b_q; acin = 1'b1; end
      OP_RSB: begin ax = b_q; ay = ~a_q; acin = 1'b1; end
      OP_ADC: acin = cin_q;
      OP_SBC: begin ay = ~b_q; acin = cin_q; end
      default: ;
    endcase
    sum = {1'b0, ax} + {1'b0, ay} + {{W{1'b0}}, acin};
  end

  // Shifters carry one extra bit so the last bit shifted out lands at a fixed index.
  logic [SHW-1:0] amt;
  logic [W:0]     lsl_w, lsr_w, asr_w;
  logic [2*W-1:0] ror_w;
  assign amt   = b_q[SHW-1:0];
  assign lsl_w = {1'b0, a_q} << amt;
  assign lsr_w = {a_q, 1'b0} >> amt;
  assign asr_w = $signed({a_q, 1'b0}) >>> amt;
  assign ror_w = {a_q, a_q} >> amt;

  logic [W-1:0] res_d;
  logic         c_d, v_d;
  always_comb begin
    res_d = result_q;
    c_d   = c_q;
    v_d   = v_q;
    case (op_q)
      OP_ADD, OP_SUB, OP_RSB, OP_ADC, OP_SBC: begin
        res_d = sum[W-1:0];
        c_d   = sum[W];
        v_d   = (ax[W-1] == ay[W-1]) && (sum[W-1] != ax[W-1]);
      end
      OP_BIC: begin res_d = a_q & ~b_q;   c_d = 1'b0; v_d = 1'b0; end
      OP_AND: begin res_d = a_q & b_q;    c_d = 1'b0; v_d = 1'b0; end
      OP_ORR: begin res_d = a_q | b_q;    c_d = 1'b0; v_d = 1'b0; end
      OP_EOR: begin res_d = a_q ^ b_q;    c_d = 1'b0; v_d = 1'b0; end
      OP_XNR: begin res_d = ~(a_q ^ b_q); c_d = 1'b0; v_d = 1'b0; end
      OP_MOV: begin res_d = b_q;          c_d = 1'b0; v_d = 1'b0; end
      OP_LSL: begin res_d = lsl_w[W-1:0]; if (amt != '0) c_d = lsl_w[W]; end
      OP_LSR: begin res_d = lsr_w[W:1];   if (amt != '0) c_d = lsr_w[0]; end
      OP_ASR: begin res_d = asr_w[W:1];   if (amt != '0) c_d = asr_w[0]; end
      OP_ROR: begin res_d = ror_w[W-1:0]; if (amt != '0) c_d = ror_w[W-1]; end
      OP_MUL: res_d = acc_nxt;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sf_q     <= 1'b0;
      cin_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= op;
        a_q   <= A;
        b_q   <= B;
        sf_q  <= set_flags;
        cin_q <= c_q;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state_q == S_MUL) begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_q + 1'b1;
      end
      if (wr_res) begin
        result_q <= res_d;
        if (sf_q) begin
          n_q <= res_d[W-1];
          z_q <= (res_d == '0);
          c_q <= c_d;
          v_q <= v_d;
        end
      end
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign N         = n_q;
  assign Z         = z_q;
  assign C         = c_q;
  assign V         = v_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (W=32): hand-computed results, flags and cycle timing.
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] A = '0, B = '0;
  logic         set_flags = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         N, Z, C, V;
  logic [3:0]   nzcv;

  int n_tests = 0;
  int n_fail  = 0;

  assign nzcv = {N, Z, C, V};

  alu_mc #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .set_flags(set_flags),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .N(N), .Z(Z), .C(C), .V(V)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op; returns 1 time unit after the accept edge with inputs scrambled.
  task automatic send(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sf);
    int guard = 0;
    while (!in_ready && guard < 100) begin tick(); guard++; end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_wait: in_ready=%0b required 1", in_ready);
    end
    op = o; A = a; B = b; set_flags = sf; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; op = 4'd0; A = 32'h1234_5678; B = 32'h0BAD_F00D; set_flags = ~sf;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // One cycle after accept: result and flags must be presented with out_valid.
  task automatic expect_single(input string name, input logic [W-1:0] r, input logic [3:0] f);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_early: out_valid=%0b required 0", name, out_valid);
    end
    tick();
    n_tests++;
    if ({out_valid, in_ready, result, nzcv} !== {1'b1, 1'b0, r, f}) begin
      n_fail++;
      $display("FAIL %s: valid=%0b rdy=%0b result=%h nzcv=%b required valid=1 rdy=0 result=%h nzcv=%b",
               name, out_valid, in_ready, result, nzcv, r, f);
    end
    retire();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_tests++;
    if ({out_valid, result, nzcv} !== '0) begin
      n_fail++; $display("FAIL reset: valid=%0b result=%h nzcv=%b required all 0", out_valid, result, nzcv);
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_add_sub();
    send(4'd0, 32'hFFFF_FFFF, 32'h1, 1'b1);
    expect_single("add_wrap", 32'h0, 4'b0110);
    send(4'd1, 32'h8000_0000, 32'h1, 1'b1);
    expect_single("sub_ovf", 32'h7FFF_FFFF, 4'b0011);
    send(4'd14, 32'h5, 32'h5, 1'b1);
    expect_single("sbc_c1", 32'h0, 4'b0110);
    send(4'd2, 32'h3, 32'h1, 1'b1);
    expect_single("rsb_borrow", 32'hFFFF_FFFE, 4'b1000);
    send(4'd13, 32'h7FFF_FFFF, 32'h0, 1'b1);
    expect_single("adc_c0", 32'h7FFF_FFFF, 4'b0000);
  endtask

  task automatic test_shift_logic();
    send(4'd9, 32'h3, 32'h21, 1'b1);
    expect_single("lsr_1", 32'h1, 4'b0010);
    send(4'd8, 32'h1234_5678, 32'h20, 1'b1);
    expect_single("lsl_0", 32'h1234_5678, 4'b0010);
    send(4'd10, 32'h8000_0000, 32'd31, 1'b1);
    expect_single("asr_31", 32'hFFFF_FFFF, 4'b1000);
    send(4'd11, 32'h1, 32'h1, 1'b1);
    expect_single("ror_1", 32'h8000_0000, 4'b1010);
    send(4'd6, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1);
    expect_single("eor", 32'hF0F0_F0F0, 4'b1000);
    send(4'd3, 32'hFFFF_0000, 32'hF0F0_F0F0, 1'b1);
    expect_single("bic", 32'h0F0F_0000, 4'b0000);
    send(4'd15, 32'hAAAA_AAAA, 32'h8000_0001, 1'b0);
    expect_single("mov_noflags", 32'h8000_0001, 4'b0000);
  endtask

  task automatic test_mul();
    int bad = 0;
    send(4'd1, 32'h8000_0000, 32'h1, 1'b1);
    expect_single("sub_pre_mul", 32'h7FFF_FFFF, 4'b0011);
    send(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    for (int i = 1; i < W; i++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL mul_busy: %0d early/ready cycles required 0", bad);
    end
    tick();
    n_tests++;
    if ({out_valid, result, nzcv} !== {1'b1, 32'h1, 4'b0011}) begin
      n_fail++;
      $display("FAIL mul_ff: valid=%0b result=%h nzcv=%b required valid=1 result=00000001 nzcv=0011",
               out_valid, result, nzcv);
    end
    retire();
    send(4'd12, 32'hFFFF_FFFE, 32'h3, 1'b1);
    repeat (W - 1) tick();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mul_early: out_valid=%0b required 0", out_valid);
    end
    tick();
    n_tests++;
    if ({out_valid, result, nzcv} !== {1'b1, 32'hFFFF_FFFA, 4'b1011}) begin
      n_fail++;
      $display("FAIL mul_neg: valid=%0b result=%h nzcv=%b required valid=1 result=fffffffa nzcv=1011",
               out_valid, result, nzcv);
    end
    retire();
  endtask

  task automatic test_backpressure();
    int bad = 0;
    send(4'd0, 32'h2, 32'h3, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      op = 4'd15; B = 32'hDEAD; set_flags = 1'b1; in_valid = (i % 2 == 0);
      if ({out_valid, in_ready, result, nzcv} !== {1'b1, 1'b0, 32'h5, 4'b1011}) bad++;
      tick();
    end
    in_valid = 1'b0;
    n_tests++;
    if (bad != 0 || {out_valid, result} !== {1'b1, 32'h5}) begin
      n_fail++; $display("FAIL backpressure: %0d unstable cycles, result=%h required 0 and 5", bad, result);
    end
    retire();
    n_tests++;
    if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 32'h5}) begin
      n_fail++;
      $display("FAIL bp_release: valid=%0b rdy=%0b result=%h required 0 1 00000005", out_valid, in_ready, result);
    end
    send(4'd15, 32'h0, 32'hDEAD, 1'b0);
    expect_single("bp_next", 32'hDEAD, 4'b1011);
  endtask

  task automatic test_reset_mid_mul();
    send(4'd12, 32'h3, 32'h4, 1'b1);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, result, nzcv} !== '0) begin
      n_fail++; $display("FAIL async_reset: valid=%0b result=%h nzcv=%b required all 0", out_valid, result, nzcv);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL reset_release: rdy=%0b valid=%0b required 1 0", in_ready, out_valid);
    end
    send(4'd0, 32'h2, 32'h3, 1'b1);
    expect_single("add_after_reset", 32'h5, 4'b0000);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_shift_logic();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
